// File: rtl/windowed_register_file_pkg.sv
// Shared definitions for the SPARC windowed register file: trap codes,
// register class bounds and the architectural-to-physical index mapping.
package sparc_rf_pkg;

    typedef enum logic [1:0] {
        TRAP_NONE   = 2'b00,
        TRAP_WOVF   = 2'b01,
        TRAP_WUNF   = 2'b10,
        TRAP_BADCWP = 2'b11
    } trap_e;

    localparam int GLOBAL_LAST = 7;
    localparam int WINDOW_SPAN = 16;

    // The windowed ring holds 16*nwindows words above the globals. Offset
    // never exceeds twice the ring size, so one conditional subtract replaces mod.
    function automatic int phys_index(input logic [4:0] r, input logic [4:0] cwp,
                                      input int nwindows);
        int ring;
        int off;
        if (int'(r) <= GLOBAL_LAST) begin
            return int'(r);
        end
        ring = WINDOW_SPAN * nwindows;
        off  = WINDOW_SPAN * int'(cwp) + int'(r) - (GLOBAL_LAST + 1);
        if (off >= ring) begin
            off = off - ring;
        end
        return GLOBAL_LAST + 1 + off;
    endfunction

endpackage

// File: rtl/windowed_register_file_window_ctrl.sv
// Window control: CWP/WIM state, SAVE/RESTORE/CWP-load resolution, the
// registered trap pulse and the window a same-cycle write should target.
module window_ctrl
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = 8
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                save_i,
    input  logic                restore_i,
    input  logic                cwp_load_i,
    input  logic [4:0]          cwp_in_i,
    input  logic                wim_enable_i,
    input  logic [NWINDOWS-1:0] wim_in_i,
    output logic [4:0]          cwp_o,
    output logic [NWINDOWS-1:0] wim_o,
    output logic                trap_o,
    output logic [1:0]          trap_type_o,
    output logic                wr_block_o,
    output logic [4:0]          wr_cwp_o
);

    localparam logic [4:0]          LAST_W = 5'(NWINDOWS - 1);
    localparam logic [NWINDOWS-1:0] BIT0   = NWINDOWS'(1);

    logic [4:0]          cwp_q, cwp_d;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    logic                trap_q, trap_d;
    trap_e               ttype_q, ttype_d;
    logic [4:0]          nxt_save, nxt_rest;
    logic                save_hit, rest_hit;

    assign nxt_save = (cwp_q == 5'd0)   ? LAST_W : cwp_q - 5'd1;
    assign nxt_rest = (cwp_q == LAST_W) ? 5'd0   : cwp_q + 5'd1;
    // Window checks always use the WIM held before this edge.
    assign save_hit = |(wim_q & (BIT0 << nxt_save));
    assign rest_hit = |(wim_q & (BIT0 << nxt_rest));

    always_comb begin
        cwp_d      = cwp_q;
        ttype_d    = TRAP_NONE;
        wr_block_o = 1'b0;
        wr_cwp_o   = cwp_q;
        wim_d      = wim_enable_i ? wim_in_i : wim_q;
        if (cwp_load_i) begin
            if (int'(cwp_in_i) < NWINDOWS) begin
                cwp_d = cwp_in_i;
            end else begin
                ttype_d    = TRAP_BADCWP;
                wr_block_o = 1'b1;
            end
        end else if (save_i && restore_i) begin
            ttype_d    = TRAP_BADCWP;
            wr_block_o = 1'b1;
        end else if (save_i) begin
            if (save_hit) begin
                ttype_d    = TRAP_WOVF;
                wr_block_o = 1'b1;
            end else begin
                cwp_d    = nxt_save;
                wr_cwp_o = nxt_save;
            end
        end else if (restore_i) begin
            if (rest_hit) begin
                ttype_d    = TRAP_WUNF;
                wr_block_o = 1'b1;
            end else begin
                cwp_d    = nxt_rest;
                wr_cwp_o = nxt_rest;
            end
        end
        trap_d = (ttype_d != TRAP_NONE);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cwp_q   <= 5'd0;
            wim_q   <= '0;
            trap_q  <= 1'b0;
            ttype_q <= TRAP_NONE;
        end else begin
            cwp_q   <= cwp_d;
            wim_q   <= wim_d;
            trap_q  <= trap_d;
            ttype_q <= ttype_d;
        end
    end

    assign cwp_o       = cwp_q;
    assign wim_o       = wim_q;
    assign trap_o      = trap_q;
    assign trap_type_o = ttype_q;

endmodule

// File: rtl/windowed_register_file.sv
// SPARC V8 windowed integer register file: flat physical storage addressed
// through the current window, with window control in window_ctrl.
module windowed_register_file
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int WIDTH    = 32
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [4:0]          in_PA,
    input  logic [4:0]          in_PB,
    output logic [WIDTH-1:0]    out_PA,
    output logic [WIDTH-1:0]    out_PB,
    input  logic [4:0]          in_PC,
    input  logic [WIDTH-1:0]    PC_data,
    input  logic                write_enable,
    input  logic                save,
    input  logic                restore,
    input  logic                cwp_load,
    input  logic [4:0]          cwp_in,
    input  logic                wim_enable,
    input  logic [NWINDOWS-1:0] wim_in,
    output logic [4:0]          cwp,
    output logic [NWINDOWS-1:0] wim_out,
    output logic                trap,
    output logic [1:0]          trap_type
);

    localparam int PHYS = GLOBAL_LAST + 1 + WINDOW_SPAN * NWINDOWS;
    localparam int AW   = $clog2(PHYS);

    logic [WIDTH-1:0] mem_q [PHYS];
    logic [AW-1:0]    idx_a, idx_b, idx_w;
    logic             wr_block;
    logic [4:0]       wr_cwp;

    window_ctrl #(
        .NWINDOWS(NWINDOWS)
    ) u_ctrl (
        .clk_i       (Clk),
        .clr_i       (Clr),
        .save_i      (save),
        .restore_i   (restore),
        .cwp_load_i  (cwp_load),
        .cwp_in_i    (cwp_in),
        .wim_enable_i(wim_enable),
        .wim_in_i    (wim_in),
        .cwp_o       (cwp),
        .wim_o       (wim_out),
        .trap_o      (trap),
        .trap_type_o (trap_type),
        .wr_block_o  (wr_block),
        .wr_cwp_o    (wr_cwp)
    );

    // Reads use the window in effect now; the write may target the rotated window.
    assign idx_a = AW'(phys_index(in_PA, cwp, NWINDOWS));
    assign idx_b = AW'(phys_index(in_PB, cwp, NWINDOWS));
    assign idx_w = AW'(phys_index(in_PC, wr_cwp, NWINDOWS));

    assign out_PA = mem_q[idx_a];
    assign out_PB = mem_q[idx_b];

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < PHYS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_enable && !wr_block && (in_PC != 5'd0)) begin
            mem_q[idx_w] <= PC_data;
        end
    end

endmodule

// File: tb/tb_windowed_register_file.sv
// Bench for windowed_register_file: directed steps then random traffic,
// compared against a window-level model of globals, outs and locals.
module tb_windowed_register_file;

    localparam int N = 8;
    localparam int W = 32;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         Clr = 1'b0;
    logic [4:0]   in_PA = '0, in_PB = '0, in_PC = '0;
    logic [W-1:0] PC_data = '0;
    logic         write_enable = 1'b0, save = 1'b0, restore = 1'b0, cwp_load = 1'b0;
    logic [4:0]   cwp_in = '0;
    logic         wim_enable = 1'b0;
    logic [N-1:0] wim_in = '0;
    logic [W-1:0] out_PA, out_PB;
    logic [4:0]   cwp;
    logic [N-1:0] wim_out;
    logic         trap;
    logic [1:0]   trap_type;

    int checks = 0;
    int errors = 0;

    windowed_register_file #(.NWINDOWS(N), .WIDTH(W)) dut (
        .Clk(Clk), .Clr(Clr), .in_PA(in_PA), .in_PB(in_PB), .out_PA(out_PA), .out_PB(out_PB),
        .in_PC(in_PC), .PC_data(PC_data), .write_enable(write_enable), .save(save),
        .restore(restore), .cwp_load(cwp_load), .cwp_in(cwp_in), .wim_enable(wim_enable),
        .wim_in(wim_in), .cwp(cwp), .wim_out(wim_out), .trap(trap), .trap_type(trap_type)
    );

    // Model: globals, per-window outs and locals; a window's ins are the outs of window+1.
    logic [W-1:0] m_g   [8];
    logic [W-1:0] m_out [N][8];
    logic [W-1:0] m_loc [N][8];
    int           m_cwp;
    logic [N-1:0] m_wim;
    logic [1:0]   m_tt;

    function automatic logic [W-1:0] mread(input int r, input int w);
        if (r == 0)       return '0;
        else if (r < 8)   return m_g[r];
        else if (r < 16)  return m_out[w][r-8];
        else if (r < 24)  return m_loc[w][r-16];
        else              return m_out[(w+1)%N][r-24];
    endfunction

    task automatic mwrite(input int r, input int w, input logic [W-1:0] d);
        if (r == 0)       ;
        else if (r < 8)   m_g[r] = d;
        else if (r < 16)  m_out[w][r-8] = d;
        else if (r < 24)  m_loc[w][r-16] = d;
        else              m_out[(w+1)%N][r-24] = d;
    endtask

    task automatic mreset();
        for (int i = 0; i < 8; i++) m_g[i] = '0;
        for (int w = 0; w < N; w++)
            for (int i = 0; i < 8; i++) begin
                m_out[w][i] = '0;
                m_loc[w][i] = '0;
            end
        m_cwp = 0;
        m_wim = '0;
        m_tt  = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl();
        chk("cwp", {27'd0, cwp}, m_cwp);
        chk("wim", {24'd0, wim_out}, {24'd0, m_wim});
        chk("trap", {31'd0, trap}, {31'd0, (m_tt != 2'b00)});
        chk("trap_type", {30'd0, trap_type}, {30'd0, m_tt});
    endtask

    // One clock: check reads against the model before the edge, then advance the model.
    task automatic cyc();
        int  nc, wwin, n;
        bit  wr_ok;
        logic [1:0] tt;
        @(negedge Clk);
        chk("rdA", out_PA, mread(int'(in_PA), m_cwp));
        chk("rdB", out_PB, mread(int'(in_PB), m_cwp));
        tt = 2'b00; nc = m_cwp; wwin = m_cwp; wr_ok = 1'b1;
        if (cwp_load) begin
            if (int'(cwp_in) < N) nc = int'(cwp_in);
            else begin tt = 2'b11; wr_ok = 1'b0; end
        end else if (save && restore) begin
            tt = 2'b11; wr_ok = 1'b0;
        end else if (save) begin
            n = (m_cwp + N - 1) % N;
            if (m_wim[n]) begin tt = 2'b01; wr_ok = 1'b0; end
            else begin nc = n; wwin = n; end
        end else if (restore) begin
            n = (m_cwp + 1) % N;
            if (m_wim[n]) begin tt = 2'b10; wr_ok = 1'b0; end
            else begin nc = n; wwin = n; end
        end
        @(posedge Clk);
        #1;
        if (Clr) begin
            mreset();
        end else begin
            if (write_enable && wr_ok) mwrite(int'(in_PC), wwin, PC_data);
            m_cwp = nc;
            if (wim_enable) m_wim = wim_in;
            m_tt = tt;
        end
        chk_ctrl();
    endtask

    task automatic idle();
        Clr = 0; write_enable = 0; save = 0; restore = 0; cwp_load = 0; wim_enable = 0;
    endtask

    task automatic expect_a(input int r, input logic [W-1:0] v, input string tag);
        in_PA = r[4:0];
        #1;
        chk(tag, out_PA, v);
    endtask

    task automatic wr(input int r, input logic [W-1:0] d);
        in_PC = r[4:0]; PC_data = d; write_enable = 1; cyc(); write_enable = 0;
    endtask

    task automatic load(input int c);
        cwp_in = c[4:0]; cwp_load = 1; cyc(); cwp_load = 0;
    endtask

    task automatic set_wim(input logic [N-1:0] m);
        wim_in = m; wim_enable = 1; cyc(); wim_enable = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        Clr = 1; cwp_load = 1; cwp_in = 5'd4;
        @(posedge Clk); #1;
        idle();
        mreset();
        chk_ctrl();
        for (int w = 0; w < N; w++) begin
            load(w);
            for (int r = 0; r < 32; r++) begin
                in_PA = r[4:0]; in_PB = 5'(31 - r);
                cyc();
            end
        end
        load(0);

        // Globals and r0
        wr(0, 32'hDEADBEEF);
        wr(5, 32'h12345678);
        expect_a(0, 32'h0, "r0_zero");
        expect_a(5, 32'h12345678, "global_r5");
        save = 1; cyc(); save = 0;
        chk("save_cwp7", {27'd0, cwp}, 32'd7);
        expect_a(5, 32'h12345678, "global_after_save");

        // Overlap
        restore = 1; cyc(); restore = 0;
        wr(8, 32'hAAAA0001);
        save = 1; cyc(); save = 0;
        expect_a(24, 32'hAAAA0001, "overlap_ins");
        wr(16, 32'h55);
        restore = 1; cyc(); restore = 0;
        chk("restore_cwp0", {27'd0, cwp}, 32'd0);
        expect_a(16, 32'h0, "locals_private");

        // Overflow with suppressed write
        set_wim(8'h80);
        save = 1; in_PC = 5'd9; PC_data = 32'h1; write_enable = 1; cyc(); idle();
        chk("ovf_trap", {31'd0, trap}, 32'd1);
        chk("ovf_type", {30'd0, trap_type}, 32'd1);
        chk("ovf_cwp", {27'd0, cwp}, 32'd0);
        expect_a(9, 32'h0, "ovf_write_suppressed");
        cyc();
        chk("trap_one_cycle", {31'd0, trap}, 32'd0);

        // Underflow, back-to-back
        set_wim(8'h02);
        restore = 1; cyc();
        chk("unf_type", {30'd0, trap_type}, 32'd2);
        cyc(); restore = 0;
        chk("unf_back_to_back", {31'd0, trap}, 32'd1);
        set_wim(8'h00);

        // CWP load
        load(9);
        chk("badcwp_type", {30'd0, trap_type}, 32'd3);
        load(3);
        chk("load3", {27'd0, cwp}, 32'd3);
        load(0);
        save = 1; load(3); save = 0;
        chk("load_over_save", {27'd0, cwp}, 32'd3);
        save = 1; restore = 1; cyc(); idle();
        chk("save_restore_both", {30'd0, trap_type}, 32'd3);
        Clr = 1; cwp_load = 1; cwp_in = 5'd20; cyc(); idle();
        chk("clr_cancels_trap", {31'd0, trap}, 32'd0);

        // Save-cycle write goes to the new window, read sees the old
        load(2);
        wr(8, 32'h11);
        save = 1; in_PC = 5'd8; PC_data = 32'h22; write_enable = 1; in_PA = 5'd8;
        #1;
        chk("save_cycle_read_old", out_PA, 32'h11);
        cyc(); idle();
        chk("save_cycle_cwp1", {27'd0, cwp}, 32'd1);
        expect_a(8, 32'h22, "save_cycle_write_new");
        restore = 1; cyc(); restore = 0;
        expect_a(8, 32'h11, "restore_sees_old");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            Clr          = ($urandom_range(0, 59) == 0);
            write_enable = $urandom_range(0, 1);
            in_PC        = 5'($urandom_range(0, 31));
            PC_data      = $urandom;
            in_PA        = 5'($urandom_range(0, 31));
            in_PB        = 5'($urandom_range(0, 31));
            save         = ($urandom_range(0, 4) == 0);
            restore      = ($urandom_range(0, 4) == 0);
            cwp_load     = ($urandom_range(0, 9) == 0);
            cwp_in       = 5'($urandom_range(0, 11));
            wim_enable   = ($urandom_range(0, 11) == 0);
            wim_in       = ($urandom_range(0, 2) == 0) ? '0 : N'(1) << $urandom_range(0, N - 1);
            cyc();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/windowed_register_file.md
Name: windowed_register_file

Overview:
- Parametrised SPARC V8 windowed integer register file. Successor to the fixed 32-entry register file.
- Adds NWINDOWS overlapping register windows, an internal CWP and WIM, SAVE/RESTORE window rotation and registered window overflow/underflow/illegal-CWP trap reporting.
- Sits between the ALU result bus and the ALUA/ALUB operand muxes. PSR and trap logic consume its cwp and trap outputs.

Parameters:
- NWINDOWS, 8, number of register windows, legal range 2..32.
- WIDTH, 32, data width of each register.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Clr  input  1  reset, synchronous, active-high.
- in_PA  input  5  read address, port A (architectural r0..r31).
- in_PB  input  5  read address, port B.
- out_PA  output  WIDTH  read data, port A, combinational.
- out_PB  output  WIDTH  read data, port B, combinational.
- in_PC  input  5  write address.
- PC_data  input  WIDTH  write data.
- write_enable  input  1  write strobe.
- save  input  1  SAVE window rotation request.
- restore  input  1  RESTORE window rotation request.
- cwp_load  input  1  load CWP from cwp_in (WRPSR/RETT path).
- cwp_in  input  5  CWP value to load.
- wim_enable  input  1  load WIM from wim_in.
- wim_in  input  NWINDOWS  new WIM value.
- cwp  output  5  current window pointer.
- wim_out  output  NWINDOWS  current WIM.
- trap  output  1  one-cycle trap pulse.
- trap_type  output  2  trap code: 00 none, 01 window_overflow, 10 window_underflow, 11 illegal_cwp.

Behaviour:
- Physical storage is 8 + 16*NWINDOWS words. r0 reads 0; writes to r0 are ignored. r1..r7 are globals mapped to physical 1..7 in every window.
- For r = 8..31: phys = 8 + ((16*cwp + (r-8)) mod (16*NWINDOWS)).
  - Within a window: outs r8-15, locals r16-23, ins r24-31.
  - Ins of window w-1 alias the outs of window w.
- Reads are combinational from current state. A read of the address being written in the same cycle returns the old value.
- Reset: Clr=1 at an edge sets cwp=0, wim=0, trap=0, trap_type=00 and all physical words to 0. Clr overrides every other input in that cycle and cancels any pending trap pulse.
- Event priority per cycle: Clr > cwp_load > save/restore.
- cwp_load:
  - cwp_in < NWINDOWS: cwp <= cwp_in.
  - Otherwise: cwp unchanged, trap type 11.
- save:
  - nxt = (cwp-1) mod NWINDOWS.
  - wim[nxt]=1: overflow, type 01, cwp unchanged.
  - Otherwise: cwp <= nxt.
- restore:
  - nxt = (cwp+1) mod NWINDOWS.
  - wim[nxt]=1: underflow, type 10, cwp unchanged.
  - Otherwise: cwp <= nxt.
- save and restore asserted together: cwp unchanged, type 11.
- Write targeting:
  - Same cycle as an accepted save/restore: the write uses the NEW window. Reads in that cycle use the OLD window (SPARC operand semantics).
  - Same cycle as any trapping event: the write is suppressed.
  - Same cycle as a legal cwp_load: the write uses the old window.
- wim_enable: wim <= wim_in at the edge. Window checks in the same cycle use the old WIM.
- trap is registered: it asserts for exactly one cycle, the cycle after the offending edge, with trap_type valid alongside. trap_type returns to 00 otherwise. Back-to-back traps give back-to-back pulses.
- Latency: writes are visible on reads the cycle after the edge. CWP/WIM changes affect reads the cycle after the edge.

Decomposition:
- Package sparc_rf_pkg holds:
  - trap code constants TRAP_NONE, TRAP_WOVF, TRAP_WUNF, TRAP_BADCWP;
  - register class bounds (GLOBAL_LAST=7, WINDOW_SPAN=16);
  - the phys_index(r, cwp, NWINDOWS) function.
- One sub-module, window_ctrl: holds the CWP/WIM registers, modular next-CWP arithmetic, priority resolution and the registered trap pulse. It outputs cwp, wim_out, trap, trap_type and a write-suppress / target-window signal to the storage array.

Test Plan:
- Reset: after one Clr cycle, cwp=0, wim=0, trap=0, and all r0..r31 read 0 in windows 0..7 (NWINDOWS=8).
- Globals and r0: write r0=0xDEADBEEF and r5=0x12345678 → r0 reads 0 and r5 reads 0x12345678. After save (cwp 0→7), r5 still reads 0x12345678.
- Overlap: at cwp=0, write r8=0xAAAA0001; save → cwp=7 and r24 reads 0xAAAA0001. Write r16=0x55; restore → cwp=0 and r16 reads 0.
- Overflow/underflow:
  - wim=0x80, cwp=0, save with write r9=1 → next cycle trap=1, type 01, cwp stays 0, r9 unchanged.
  - wim=0x02, cwp=0, restore → type 10, cwp stays 0.
- CWP load: cwp_load with cwp_in=9 → type 11, cwp unchanged. cwp_in=3 → cwp=3, no trap. cwp_load together with save at cwp_in=3 → cwp=3 and save ignored.
- Save-cycle write: cwp=2, r8=0x11 written earlier. Same cycle: save, write r8=0x22, in_PA=8 → out_PA=0x11. Next cycle cwp=1 and r8 reads 0x22. After restore, r8 reads 0x11.
